// File: rtl/bounce_gen_if.sv
// ============================================================================
// bounce_gen_if : press request / bouncy button handshake bundle
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface bounce_gen_if;
  logic       press_req;
  logic       trigger;
  logic       busy;
  logic       press_ack;
  logic [7:0] press_count;

  modport master (
    output press_req,
    input  trigger,
    input  busy,
    input  press_ack,
    input  press_count
  );

  modport slave (
    input  press_req,
    output trigger,
    output busy,
    output press_ack,
    output press_count
  );
endinterface

`default_nettype wire

// File: rtl/bounce_gen.sv
// ============================================================================
// bounce_gen : mechanical push-button emulator with LFSR-timed contact bounce
//              Optional abort input enabled by BOUNCE_GEN_ABORT_EN.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module bounce_gen #(
  parameter int         BOUNCES   = 4,
  parameter int         GAP_BITS  = 4,
  parameter int         HOLD      = 64,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic clock,
  input  logic reset,
`ifdef BOUNCE_GEN_ABORT_EN
  input  logic abort,
`endif
  bounce_gen_if.slave bus
);

  localparam int BW = $clog2(BOUNCES + 2);
  localparam int HW = $clog2(HOLD + 1);
  localparam int GW = GAP_BITS + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRESS_BNC = 3'd1;
  localparam logic [2:0] S_HOLD_HI   = 3'd2;
  localparam logic [2:0] S_REL_BNC   = 3'd3;
  localparam logic [2:0] S_HOLD_LO   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          trig_q, trig_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic [7:0]    count_q, count_d;
  logic [GW-1:0] gap_load;
`ifdef BOUNCE_GEN_ABORT_EN
  logic          aborted_q, aborted_d;
`endif

  assign gap_load = GW'(lfsr_q[GAP_BITS-1:0]) + GW'(1);

  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    state_d = state_q;
    bcnt_d  = bcnt_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    trig_d  = trig_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    count_d = count_q;
`ifdef BOUNCE_GEN_ABORT_EN
    aborted_d = aborted_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.press_req) begin
          trig_d = 1'b1;
          busy_d = 1'b1;
`ifdef BOUNCE_GEN_ABORT_EN
          aborted_d = 1'b0;
`endif
          if (BOUNCES > 0) begin
            state_d = S_PRESS_BNC;
            bcnt_d  = BW'(BOUNCES);
            gap_d   = gap_load;
          end else begin
            state_d = S_HOLD_HI;
            hold_d  = HW'(HOLD);
          end
        end
      end
      S_PRESS_BNC, S_REL_BNC: begin
        if (gap_q == GW'(1)) begin
          trig_d = ~trig_q;
          bcnt_d = bcnt_q - BW'(1);
          gap_d  = gap_load;
          // Even bounce count leaves the line at the level of the edge being emulated
          if (bcnt_q == BW'(1)) begin
            state_d = (state_q == S_PRESS_BNC) ? S_HOLD_HI : S_HOLD_LO;
            hold_d  = HW'(HOLD);
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_HOLD_HI: begin
        if (hold_q == HW'(1)) begin
          trig_d = 1'b0;
          if (BOUNCES > 0) begin
            state_d = S_REL_BNC;
            bcnt_d  = BW'(BOUNCES);
            gap_d   = gap_load;
          end else begin
            state_d = S_HOLD_LO;
            hold_d  = HW'(HOLD);
          end
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      S_HOLD_LO: begin
        if (hold_q == HW'(1)) state_d = S_DONE;
        else                  hold_d  = hold_q - HW'(1);
      end
      S_DONE: begin
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef BOUNCE_GEN_ABORT_EN
        if (!aborted_q) count_d = count_q + 8'd1;
`else
        count_d = count_q + 8'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef BOUNCE_GEN_ABORT_EN
    if (abort && (state_q == S_PRESS_BNC || state_q == S_HOLD_HI ||
                  state_q == S_REL_BNC)) begin
      trig_d    = 1'b0;
      state_d   = S_HOLD_LO;
      hold_d    = HW'(HOLD);
      aborted_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      bcnt_q  <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      count_q <= 8'd0;
`ifdef BOUNCE_GEN_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      bcnt_q  <= bcnt_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      count_q <= count_d;
`ifdef BOUNCE_GEN_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign bus.trigger     = trig_q;
  assign bus.busy        = busy_q;
  assign bus.press_ack   = ack_q;
  assign bus.press_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_bounce_gen.sv
// ============================================================================
// tb_bounce_gen : random-timed presses on three bounce_gen configurations,
//                 checked cycle by cycle against a segment-level waveform model.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_bounce_gen;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bounce_gen_if if_a ();
  bounce_gen_if if_b ();
  bounce_gen_if if_c ();

`ifdef BOUNCE_GEN_ABORT_EN
  logic abort_t = 1'b0;
`endif

  bounce_gen u_a (
    .clock (clock),
    .reset (reset),
`ifdef BOUNCE_GEN_ABORT_EN
    .abort (abort_t),
`endif
    .bus   (if_a.slave)
  );

  bounce_gen #(.BOUNCES(0), .HOLD(4)) u_b (
    .clock (clock),
    .reset (reset),
`ifdef BOUNCE_GEN_ABORT_EN
    .abort (abort_t),
`endif
    .bus   (if_b.slave)
  );

  bounce_gen #(.BOUNCES(0), .HOLD(1)) u_c (
    .clock (clock),
    .reset (reset),
`ifdef BOUNCE_GEN_ABORT_EN
    .abort (abort_t),
`endif
    .bus   (if_c.slave)
  );

  int         sel = 0;
  logic       o_trig, o_busy, o_ack;
  logic [7:0] o_cnt;

  always_comb begin
    case (sel)
      1:       begin o_trig = if_b.trigger; o_busy = if_b.busy; o_ack = if_b.press_ack; o_cnt = if_b.press_count; end
      2:       begin o_trig = if_c.trigger; o_busy = if_c.busy; o_ack = if_c.press_ack; o_cnt = if_c.press_count; end
      default: begin o_trig = if_a.trigger; o_busy = if_a.busy; o_ack = if_a.press_ack; o_cnt = if_a.press_count; end
    endcase
  end

  // Index of the next rising edge since reset release; selects the LFSR value seen there
  int edge_n;
  always @(posedge clock or negedge reset) begin
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  int         errs = 0;
  int         nchk = 0;
  logic [7:0] mc [3];

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] v = 8'hA5;
    for (int k = 0; k < n; k++) v = lfsr_step(v);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int s, input logic v);
    case (s)
      1:       if_b.press_req = v;
      2:       if_c.press_req = v;
      default: if_a.press_req = v;
    endcase
  endtask

  task automatic check_idle_zero(input string tag);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      chk({tag, "_trig"}, 32'(o_trig), 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_ack"},  32'(o_ack),  32'd0);
      chk({tag, "_cnt"},  32'(o_cnt),  32'd0);
    end
  endtask

  // Expected waveform: alternating segments of random gap length, then a HOLD plateau,
  // for press then release, followed by the single DONE cycle.
  task automatic do_press(input int s, input int bounces, input int hold, input bit collide);
    logic       exp_q[$];
    logic [7:0] v;
    logic       lvl, prev;
    int         e0, g, len, cpos, rise, fall;
    sel = s;
    @(negedge clock);
    e0 = edge_n;
    set_req(s, 1'b1);
    v = lfsr_at(e0);
    for (int ph = 0; ph < 2; ph++) begin
      lvl = (ph == 0);
      for (int b = 0; b <= bounces; b++) begin
        if (b < bounces) begin
          g = int'(v[3:0]) + 1;
          repeat (g) begin exp_q.push_back(lvl); v = lfsr_step(v); end
          lvl = ~lvl;
        end else begin
          repeat (hold) begin exp_q.push_back(lvl); v = lfsr_step(v); end
        end
      end
    end
    exp_q.push_back(1'b0);
    len  = exp_q.size();
    cpos = collide ? int'($urandom_range(2, len - 3)) : -5;
    rise = 0; fall = 0; prev = 1'b0;
    for (int i = 0; i <= len; i++) begin
      @(posedge clock);
      #1;
      if (i == 0)        set_req(s, 1'b0);
      if (i == cpos)     set_req(s, 1'b1);
      if (i == cpos + 1) set_req(s, 1'b0);
      if (o_trig && !prev) rise++;
      if (!o_trig && prev) fall++;
      prev = o_trig;
      if (i < len) begin
        chk("trigger", 32'(o_trig), 32'(exp_q[i]));
        chk("busy",    32'(o_busy), 32'd1);
        chk("ack_low", 32'(o_ack),  32'd0);
      end else begin
        mc[s] = mc[s] + 8'd1;
        chk("trig_end",  32'(o_trig), 32'd0);
        chk("busy_end",  32'(o_busy), 32'd0);
        chk("ack_pulse", 32'(o_ack),  32'd1);
        chk("count",     32'(o_cnt),  32'(mc[s]));
      end
    end
    chk("rise_edges", 32'(rise), 32'(bounces + 1));
    chk("fall_edges", 32'(fall), 32'(bounces + 1));
    @(posedge clock);
    #1;
    chk("ack_single", 32'(o_ack),  32'd0);
    chk("idle_busy",  32'(o_busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    set_req(0, 1'b0); set_req(1, 1'b0); set_req(2, 1'b0);
    mc[0] = 8'd0; mc[1] = 8'd0; mc[2] = 8'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle_zero("por");
    reset = 1'b1;

    do_press(0, 4, 64, 1'b0);

    // Abort mid-press with reset, then the first press must replay the power-on waveform
    sel = 0;
    @(negedge clock);
    set_req(0, 1'b1);
    @(negedge clock);
    set_req(0, 1'b0);
    repeat ($urandom_range(10, 120)) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check_idle_zero("rst");
    mc[0] = 8'd0; mc[1] = 8'd0; mc[2] = 8'd0;
    reset = 1'b1;
    do_press(0, 4, 64, 1'b0);

    repeat ($urandom_range(0, 20)) @(negedge clock);
    do_press(0, 4, 64, 1'b1);

    repeat ($urandom_range(0, 7)) @(negedge clock);
    do_press(1, 0, 4, 1'b0);
    repeat ($urandom_range(0, 7)) @(negedge clock);
    do_press(1, 0, 4, 1'b1);

    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(0, 30)) @(negedge clock);
      do_press(0, 4, 64, r[0]);
    end

    sel = 2;
    acks = 0;
    @(negedge clock);
    set_req(2, 1'b1);
    for (int k = 0; k < 1200 && acks < 256; k++) begin
      @(posedge clock);
      #1;
      if (o_ack) begin
        acks++;
        chk("wrap_count", 32'(o_cnt), 32'(acks % 256));
      end
    end
    set_req(2, 1'b0);
    chk("wrap_acks",  32'(acks),  32'd256);
    chk("wrap_final", 32'(o_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bounce_gen.md
Name: bounce_gen

Overview:
- Emulates a mechanical push-button for bench and hardware-in-loop self-test of the lab debounce counter.
- Turns a clean press request into a `trigger` waveform with pseudo-random contact bounce on both the press and release edges.
- `trigger` connects directly to the debounce counter's `trigger` input. `press_count` is the golden count that the counter's `count` output must match.

Parameters:
- BOUNCES, 4: extra toggles per edge after the initial transition. Must be even; 0 gives clean edges.
- GAP_BITS, 4: width of the random bounce gap. Each gap lasts lfsr[GAP_BITS-1:0]+1 cycles, i.e. 1..2^GAP_BITS.
- HOLD, 64: cycles of stable level after the press bounce and after the release bounce. Must be at least 1.
- LFSR_SEED, 8'hA5: reset value of the LFSR. Must be nonzero.

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- press_req  in  1  level request for one press/release cycle
- trigger  out  1  emulated bouncy button line, registered
- busy  out  1  high while a press cycle is in progress
- press_ack  out  1  one-cycle pulse when a press cycle completes
- press_count  out  8  number of completed press cycles, wraps 255->0

Behaviour:
- Reset (reset=0, asynchronous): trigger=0, busy=0, press_ack=0, press_count=0, lfsr=LFSR_SEED, state=IDLE. Reset mid-operation aborts immediately; no partial count is recorded.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clock regardless of state.
- Gap counter: loaded with lfsr[GAP_BITS-1:0]+1 at each load point.
- FSM states: IDLE, PRESS_BNC, HOLD_HI, REL_BNC, HOLD_LO, DONE.
- IDLE:
  - trigger=0, busy=0.
  - press_req=1 at an edge: trigger<=1 and busy<=1 on that edge.
  - If BOUNCES>0: go to PRESS_BNC, bounce_cnt<=BOUNCES, load gap.
  - Else: go to HOLD_HI, hold_cnt<=HOLD.
- PRESS_BNC:
  - Decrement gap each cycle.
  - When gap reaches 1: toggle trigger, decrement bounce_cnt, reload gap.
  - When bounce_cnt reaches 0 after its toggle: go to HOLD_HI with hold_cnt<=HOLD. trigger is 1 here because BOUNCES is even.
- HOLD_HI:
  - trigger held 1 for exactly HOLD cycles.
  - Then trigger<=0 and go to REL_BNC (load bounce_cnt and gap) or, if BOUNCES=0, to HOLD_LO.
- REL_BNC: same toggle mechanics as PRESS_BNC; ends with trigger=0, then go to HOLD_LO with hold_cnt<=HOLD.
- HOLD_LO: trigger held 0 for exactly HOLD cycles, then go to DONE.
- DONE (one cycle): press_ack=1, busy=0, press_count<=press_count+1 (8-bit wrap), next state IDLE.
- Edge counts per press cycle: rising edges of trigger = BOUNCES+1, falling edges = BOUNCES+1. Default is 5 each.
- With BOUNCES=0: trigger high exactly HOLD cycles, then low HOLD cycles. press_ack asserts 2*HOLD+1 cycles after the request edge.
- press_req while busy: ignored, not queued.
- press_req still high in the IDLE cycle after DONE: a new cycle starts, because the request is level-sensitive.
- No combinational path from press_req to any output.

Optional Feature:
- Macro: BOUNCE_GEN_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - abort=1 at an edge in PRESS_BNC, HOLD_HI or REL_BNC: trigger<=0, go to HOLD_LO with hold_cnt<=HOLD.
  - The cycle still ends through DONE, but press_count does not increment for an aborted cycle. press_ack still pulses.
  - abort in IDLE, HOLD_LO or DONE has no effect.
- Undefined: no `abort` port; the FSM has no abort transitions.

Test Plan:
- Reset: hold reset=0 for 5 cycles mid-press, then release -> trigger=0, busy=0, press_ack=0, press_count=0. First post-reset press shows the same trigger waveform as a press from power-on.
- Clean press (BOUNCES=0, HOLD=4): 1-cycle press_req -> trigger high exactly 4 cycles, low 4 cycles. press_ack pulses 9 cycles after the request edge. press_count=1.
- Bouncy press (defaults): one press_req -> exactly 5 rising and 5 falling trigger edges. trigger stable 1 for 64 cycles, then stable 0 for 64 cycles. press_count=1.
- Busy collision: pulse press_req again while busy=1 -> no effect on trigger; exactly one press_ack; press_count=1.
- Wrap (HOLD=1, BOUNCES=0): 256 back-to-back presses with press_req held high -> press_count returns to 0 and 256 press_ack pulses are seen.
- Abort (BOUNCE_GEN_ABORT_EN, BOUNCES=0, HOLD=8): assert abort 3 cycles into HOLD_HI -> trigger=0 on the next edge. press_ack follows 9 cycles after the abort edge; press_count is unchanged.
